// File: rtl/score_uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// pong_defs: constants and helper functions shared by the score telemetry path.
//   ASC_*      ASCII codes used to build the "S<p1>-<p2>\r\n" line
//   MSG_LEN    number of bytes in one score message
//   msg_state_e  message FSM state encoding
//   hex_ascii  4-bit value -> uppercase ASCII hex digit
//   msg_byte   byte <idx> of the message for a given score pair
// ---------------------------------------------------------------------------
package pong_defs;

  localparam logic [7:0] ASC_S    = 8'h53;
  localparam logic [7:0] ASC_DASH = 8'h2D;
  localparam logic [7:0] ASC_CR   = 8'h0D;
  localparam logic [7:0] ASC_LF   = 8'h0A;
  localparam logic [7:0] ASC_0    = 8'h30;
  localparam logic [7:0] ASC_A    = 8'h41;

  localparam int MSG_LEN = 6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } msg_state_e;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n <= 4'd9) return ASC_0 + {4'h0, n};
    else           return ASC_A + {4'h0, n - 4'd10};
  endfunction

  function automatic logic [7:0] msg_byte(input logic [2:0] idx,
                                          input logic [3:0] p1,
                                          input logic [3:0] p2);
    case (idx)
      3'd0:    return ASC_S;
      3'd1:    return hex_ascii(p1);
      3'd2:    return ASC_DASH;
      3'd3:    return hex_ascii(p2);
      3'd4:    return ASC_CR;
      default: return ASC_LF;
    endcase
  endfunction

endpackage

// File: rtl/score_uart_tx_byte.sv
// ---------------------------------------------------------------------------
// uart_tx_byte: 8N1 serialiser, LSB first, idle high.
//   clk, reset  system clock, asynchronous active-low reset
//   valid, data byte offered by the producer
//   ready       byte can be accepted this cycle (idle, or final cycle of the
//               current stop bit so consecutive bytes run back-to-back)
//   tx          registered serial output
// Each bit is held for CLKDIV clock cycles.
// ---------------------------------------------------------------------------
module uart_tx_byte #(
  parameter int CLKDIV = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int              BW       = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [BW-1:0]   BAUD_MAX = BW'(CLKDIV - 1);
  localparam logic [3:0]      LAST_BIT = 4'd9;  // start, d0..d7, stop

  logic          active_q, active_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    shift_q, shift_d;   // remaining data bits plus the stop bit
  logic          tx_q, tx_d;
  logic          bit_end, frame_end;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    active_d  = active_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tx_d      = tx_q;

    bit_end   = active_q && (baud_q == BAUD_MAX);
    frame_end = bit_end && (bit_q == LAST_BIT);
    ready     = !active_q || frame_end;

    if (valid && ready) begin
      active_d = 1'b1;
      baud_d   = '0;
      bit_d    = 4'd0;
      shift_d  = {1'b1, data};
      tx_d     = 1'b0;              // start bit
    end else if (frame_end) begin
      active_d = 1'b0;
      baud_d   = '0;
      bit_d    = 4'd0;
      tx_d     = 1'b1;
    end else if (bit_end) begin
      baud_d   = '0;
      bit_d    = bit_q + 4'd1;
      tx_d     = shift_q[0];
      shift_d  = {1'b1, shift_q[8:1]};
    end else if (active_q) begin
      baud_d   = baud_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together on the edge regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= 4'd0;
      shift_q  <= 9'h1FF;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: rtl/score_uart_tx.sv
// ---------------------------------------------------------------------------
// score_uart_tx: reports every scoreboard change as "S<p1>-<p2>\r\n" on a
// UART pin.
//   clk       system clock
//   reset     asynchronous active-low reset
//   score_p1  player 1 score (0..15)
//   score_p2  player 2 score (0..15)
//   tx        UART 8N1 output, idle high (registered)
//   busy      high while a message is in flight (registered)
// Changes arriving during a message are coalesced: only the value present
// when the FSM returns to idle is reported.
// ---------------------------------------------------------------------------
module score_uart_tx
  import pong_defs::*;
#(
  parameter int CLKDIV = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] score_p1,
  input  logic [3:0] score_p2,
  output logic       tx,
  output logic       busy
);

  localparam logic [2:0] LAST_IDX = 3'(MSG_LEN - 1);

  msg_state_e state_q, state_d;
  logic [7:0] snap_q, snap_d;       // {p1,p2} of the last message started
  logic [2:0] byte_idx_q, byte_idx_d;
  logic       busy_q, busy_d;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    byte_idx_d = byte_idx_q;
    busy_d     = busy_q;
    byte_valid = 1'b0;
    byte_data  = ASC_S;

    case (state_q)
      ST_IDLE: begin
        if (({score_p1, score_p2} != snap_q) && byte_ready) begin
          byte_valid = 1'b1;        // byte 0 is always 'S'
          snap_d     = {score_p1, score_p2};
          byte_idx_d = 3'd0;
          state_d    = ST_SEND;
          busy_d     = 1'b1;
        end
      end
      default: begin
        // While sending, ready only pulses in the final stop-bit cycle.
        if (byte_ready) begin
          if (byte_idx_q == LAST_IDX) begin
            state_d    = ST_IDLE;
            byte_idx_d = 3'd0;
            busy_d     = 1'b0;
          end else begin
            byte_valid = 1'b1;
            byte_data  = msg_byte(byte_idx_q + 3'd1, snap_q[7:4], snap_q[3:0]);
            byte_idx_d = byte_idx_q + 3'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      snap_q     <= 8'h00;
      byte_idx_q <= 3'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      byte_idx_q <= byte_idx_d;
      busy_q     <= busy_d;
    end
  end

  uart_tx_byte #(.CLKDIV(CLKDIV)) u_tx (
    .clk   (clk),
    .reset (reset),
    .valid (byte_valid),
    .data  (byte_data),
    .ready (byte_ready),
    .tx    (tx)
  );

  assign busy = busy_q;

endmodule
